// File: rtl/disp_pkg.sv
// Shared definitions for the display VRAM reader: AXI encodings, FSM state type
// and frame-geometry helpers.
package disp_pkg;

    localparam logic [2:0] ARSIZE_8B    = 3'b011;
    localparam logic [1:0] ARBURST_INCR = 2'b01;
    localparam logic [1:0] RRESP_OKAY   = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ADDR,
        DATA
    } state_t;

    // Two pixels are packed into every 64-bit word.
    function automatic int unsigned calc_words(input int unsigned h_pixels,
                                               input int unsigned v_lines);
        return (h_pixels * v_lines) / 2;
    endfunction

    function automatic int unsigned calc_nburst(input int unsigned h_pixels,
                                                input int unsigned v_lines,
                                                input int unsigned burst_len);
        return calc_words(h_pixels, v_lines) / burst_len;
    endfunction

endpackage

// File: rtl/disp_vram_reader.sv
// AXI4 read master fetching one display frame from VRAM in fixed-length INCR
// bursts and pushing the beats into the display pixel FIFO.
module disp_vram_reader
    import disp_pkg::*;
#(
    parameter int unsigned H_PIXELS  = 640,
    parameter int unsigned V_LINES   = 480,
    parameter int unsigned BURST_LEN = 128
) (
    input  logic        ACLK,
    input  logic        ARST,
    input  logic        DISPON,
    input  logic        FRAME_START,
    input  logic [31:0] VRAMSTART,
    input  logic        BUF_WREADY,
    output logic [63:0] FIFOIN,
    output logic        FIFOWR,
    output logic        FIFORST,
    output logic [31:0] ARADDR,
    output logic [7:0]  ARLEN,
    output logic [2:0]  ARSIZE,
    output logic [1:0]  ARBURST,
    output logic        ARVALID,
    input  logic        ARREADY,
    input  logic [63:0] RDATA,
    input  logic [1:0]  RRESP,
    input  logic        RLAST,
    input  logic        RVALID,
    output logic        RREADY,
    output logic        RD_ERR,
    output logic        FRAME_LATE
);

    localparam int unsigned      NBURST     = calc_nburst(H_PIXELS, V_LINES, BURST_LEN);
    localparam int unsigned      CNT_W      = $clog2(NBURST + 1);
    localparam logic [31:0]      STRIDE     = 32'(BURST_LEN * 8);
    localparam logic [CNT_W-1:0] LAST_BURST = CNT_W'(NBURST - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] burst_cnt;
    logic             abort;
    logic             abort_now;
    logic             beat;
    logic             last_beat;
    logic             start_ok;

    assign ARLEN   = 8'(BURST_LEN - 1);
    assign ARSIZE  = ARSIZE_8B;
    assign ARBURST = ARBURST_INCR;
    assign ARVALID = (state == ADDR);
    assign RREADY  = (state == DATA);

    assign start_ok  = (state == IDLE) && FRAME_START && DISPON;
    assign beat      = (state == DATA) && RVALID;
    assign last_beat = beat && RLAST;
    // A beat arriving in the very cycle DISPON falls is already discarded.
    assign abort_now = abort || !DISPON;

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start_ok) state_next = WAIT;
            WAIT: begin
                if (!DISPON)         state_next = IDLE;
                else if (BUF_WREADY) state_next = ADDR;
            end
            ADDR: if (ARREADY) state_next = DATA;
            DATA: begin
                if (last_beat) begin
                    if (abort_now || burst_cnt == LAST_BURST) state_next = IDLE;
                    else                                      state_next = WAIT;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) state <= IDLE;
        else      state <= state_next;
    end

    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            ARADDR     <= '0;
            burst_cnt  <= '0;
            abort      <= 1'b0;
            RD_ERR     <= 1'b0;
            FIFOIN     <= '0;
            FIFOWR     <= 1'b0;
            FIFORST    <= 1'b1;
            FRAME_LATE <= 1'b0;
        end else begin
            FIFOWR     <= beat && !abort_now;
            FIFORST    <= !DISPON || start_ok;
            FRAME_LATE <= FRAME_START && (state != IDLE);
            if (beat && !abort_now) FIFOIN <= RDATA;

            if (start_ok) begin
                ARADDR    <= VRAMSTART;
                burst_cnt <= '0;
                RD_ERR    <= 1'b0;
            end else begin
                if (beat && RRESP != RRESP_OKAY) RD_ERR <= 1'b1;
                if (last_beat) begin
                    ARADDR    <= ARADDR + STRIDE;
                    burst_cnt <= burst_cnt + 1'b1;
                end
            end

            // The outstanding burst always completes on AXI; the flag only gates writes.
            if (state == IDLE)
                abort <= 1'b0;
            else if ((state == ADDR || state == DATA) && !DISPON)
                abort <= 1'b1;
        end
    end

endmodule

// File: tb/tb_disp_vram_reader.sv
// Self-checking bench for disp_vram_reader: AXI slave model, address/data
// scoreboards, table-driven frame scenarios and hand-written corner cases.
module tb_disp_vram_reader;

    localparam int unsigned HP = 16;
    localparam int unsigned VL = 4;
    localparam int unsigned BL = 8;
    localparam int          NB = 4;
    localparam logic [31:0] STRIDE = 32'h40;

    logic        ACLK = 1'b0;
    logic        ARST;
    logic        DISPON;
    logic        FRAME_START;
    logic [31:0] VRAMSTART;
    logic        BUF_WREADY;
    logic [63:0] FIFOIN;
    logic        FIFOWR;
    logic        FIFORST;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [63:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;
    logic        RD_ERR;
    logic        FRAME_LATE;

    always #5 ACLK = ~ACLK;

    disp_vram_reader #(.H_PIXELS(HP), .V_LINES(VL), .BURST_LEN(BL)) dut (
        .ACLK(ACLK), .ARST(ARST), .DISPON(DISPON), .FRAME_START(FRAME_START),
        .VRAMSTART(VRAMSTART), .BUF_WREADY(BUF_WREADY), .FIFOIN(FIFOIN),
        .FIFOWR(FIFOWR), .FIFORST(FIFORST), .ARADDR(ARADDR), .ARLEN(ARLEN),
        .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
        .RREADY(RREADY), .RD_ERR(RD_ERR), .FRAME_LATE(FRAME_LATE)
    );

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] base;
        int          ar_delay;
        bit          rv_toggle;
        int          stall_after;
        int          exp_writes;
    } vec_t;

    int total = 0;
    int bad   = 0;

    exp_t        dq[$];
    logic [31:0] exp_addr[$];

    int cycle = 0;
    int ar_count, wr_count, accepted;
    int beats_left, beat_idx, ar_wait, stall_cnt;
    int rise_cyc, abort_cyc, err_cyc;
    bit ar_seen, tog, discard, abort_hit, dispon_cmd;
    int ar_delay, stall_after, abort_burst, abort_beat, err_burst, err_beat;
    bit rv_toggle;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Observes the results of the last rising edge, then drives slave inputs
    // for the next one; everything happens on the falling edge.
    task automatic monitor();
        exp_t e;
        if (FIFOWR) begin
            wr_count++;
            if (dq.size() == 0) begin
                check("fifowr_unexpected", 64'(FIFOWR), 64'(0));
            end else begin
                e = dq.pop_front();
                check("fifoin", FIFOIN, e.data);
                check("fifowr_latency", 64'(cycle), 64'(e.cyc + 1));
            end
        end
        if (stall_cnt > 0) check("no_arvalid_in_stall", 64'(ARVALID), 64'(0));
        if (abort_cyc >= 0 && cycle == abort_cyc + 1)
            check("fiforst_after_abort", 64'(FIFORST), 64'(1));
        if (err_cyc >= 0 && cycle == err_cyc + 1)
            check("rd_err_set", 64'(RD_ERR), 64'(1));

        DISPON = dispon_cmd && !abort_hit;
        if (stall_cnt > 0) begin
            stall_cnt--;
            if (stall_cnt == 0) begin
                BUF_WREADY = 1'b1;
                rise_cyc   = cycle;
            end
        end

        ARREADY = 1'b0;
        if (ARVALID) begin
            if (!ar_seen) begin
                ar_seen = 1'b1;
                ar_wait = ar_delay;
                if (rise_cyc >= 0) begin
                    check("burst_after_stall", 64'((cycle - rise_cyc) <= 2), 64'(1));
                    rise_cyc = -1;
                end
            end
            if (exp_addr.size() == 0) check("araddr_unexpected", 64'(ARVALID), 64'(0));
            else                      check("araddr", 64'(ARADDR), 64'(exp_addr[0]));
            if (ar_wait > 0) begin
                ar_wait--;
            end else begin
                ARREADY = 1'b1;
                if (exp_addr.size() > 0) void'(exp_addr.pop_front());
                check("arlen", 64'(ARLEN), 64'(BL - 1));
                check("arsize", 64'(ARSIZE), 64'(3));
                check("arburst", 64'(ARBURST), 64'(1));
                ar_seen    = 1'b0;
                ar_count++;
                beats_left = BL;
                beat_idx   = 0;
            end
        end

        RVALID = 1'b0;
        RLAST  = 1'b0;
        RRESP  = 2'b00;
        tog    = !tog;
        if (beats_left > 0 && RREADY && (!rv_toggle || tog)) begin
            RVALID = 1'b1;
            RDATA  = {$urandom, $urandom};
            RLAST  = (beats_left == 1);
            if (err_burst == ar_count - 1 && err_beat == beat_idx) begin
                RRESP   = 2'b10;
                err_cyc = cycle;
            end
            if (abort_burst == ar_count - 1 && abort_beat == beat_idx) begin
                abort_hit = 1'b1;
                DISPON    = 1'b0;
                abort_cyc = cycle;
            end
            if (!DISPON) discard = 1'b1;
            if (!discard) dq.push_back('{RDATA, cycle});
            accepted++;
            beat_idx++;
            beats_left--;
            if (beats_left == 0 && stall_after == ar_count - 1) begin
                BUF_WREADY = 1'b0;
                stall_cnt  = 20;
            end
        end
    endtask

    task automatic cyc();
        @(negedge ACLK);
        cycle++;
        monitor();
    endtask

    task automatic start_frame(input logic [31:0] base);
        VRAMSTART = base;
        exp_addr.delete();
        for (int i = 0; i < NB; i++) exp_addr.push_back(base + STRIDE * 32'(i));
        discard  = 1'b0;
        ar_count = 0;
        wr_count = 0;
        accepted = 0;
        FRAME_START = 1'b1;
        cyc();
        FRAME_START = 1'b0;
        check("fiforst_pulse", 64'(FIFORST), 64'(1));
        check("rd_err_clear", 64'(RD_ERR), 64'(0));
        cyc();
        check("fiforst_low", 64'(FIFORST), 64'(0));
    endtask

    task automatic wait_frame(input int exp_wr, input string tag);
        int n = 0;
        while (!(ar_count == NB && beats_left == 0 && dq.size() == 0) && n < 2000) begin
            cyc();
            n++;
        end
        check({tag, "_timeout"}, 64'(n < 2000), 64'(1));
        repeat (4) cyc();
        check({tag, "_writes"}, 64'(wr_count), 64'(exp_wr));
        check({tag, "_bursts"}, 64'(ar_count), 64'(NB));
        check({tag, "_addr_left"}, 64'(exp_addr.size()), 64'(0));
        check({tag, "_idle_arvalid"}, 64'(ARVALID), 64'(0));
        check({tag, "_idle_rready"}, 64'(RREADY), 64'(0));
    endtask

    vec_t vecs[3];

    initial begin
        vecs[0] = '{32'h1000_0000, 0, 1'b0, -1, 32};
        vecs[1] = '{32'h2000_0400, 0, 1'b0,  0, 32};
        vecs[2] = '{32'h3000_0000, 5, 1'b1, -1, 32};

        ARST = 1'b1; DISPON = 1'b0; FRAME_START = 1'b0; VRAMSTART = '0;
        BUF_WREADY = 1'b1; ARREADY = 1'b0; RDATA = '0; RRESP = '0;
        RLAST = 1'b0; RVALID = 1'b0;
        ar_count = 0; wr_count = 0; accepted = 0; beats_left = 0; beat_idx = 0;
        ar_wait = 0; stall_cnt = 0; rise_cyc = -1; abort_cyc = -1; err_cyc = -1;
        ar_seen = 0; tog = 0; discard = 0; abort_hit = 0; dispon_cmd = 0;
        ar_delay = 0; stall_after = -1; abort_burst = -1; abort_beat = -1;
        err_burst = -1; err_beat = -1; rv_toggle = 0;

        repeat (3) cyc();
        check("rst_fiforst", 64'(FIFORST), 64'(1));
        check("rst_arvalid", 64'(ARVALID), 64'(0));
        check("rst_araddr", 64'(ARADDR), 64'(0));
        check("rst_rready", 64'(RREADY), 64'(0));
        check("rst_fifowr", 64'(FIFOWR), 64'(0));
        check("rst_fifoin", FIFOIN, 64'(0));
        check("rst_rd_err", 64'(RD_ERR), 64'(0));
        check("rst_frame_late", 64'(FRAME_LATE), 64'(0));
        ARST = 1'b0;
        dispon_cmd = 1'b1;
        repeat (3) cyc();
        check("fiforst_dispon_on", 64'(FIFORST), 64'(0));

        // Nominal, backpressure and AXI-stall frames
        for (int v = 0; v < 3; v++) begin
            ar_delay    = vecs[v].ar_delay;
            rv_toggle   = vecs[v].rv_toggle;
            stall_after = vecs[v].stall_after;
            start_frame(vecs[v].base);
            wait_frame(vecs[v].exp_writes, $sformatf("vec%0d", v));
        end
        ar_delay = 0; rv_toggle = 0; stall_after = -1;

        // Abort in the middle of the second burst
        abort_burst = 1; abort_beat = 3;
        start_frame(32'h4000_0000);
        begin
            int n = 0;
            while (!(ar_count == 2 && beats_left == 0) && n < 1000) begin cyc(); n++; end
            check("abort_timeout", 64'(n < 1000), 64'(1));
        end
        repeat (10) cyc();
        check("abort_writes", 64'(wr_count), 64'(11));
        check("abort_beats_accepted", 64'(accepted), 64'(16));
        check("abort_no_more_bursts", 64'(ar_count), 64'(2));
        check("abort_fiforst_held", 64'(FIFORST), 64'(1));
        abort_burst = -1; abort_hit = 1'b0; dispon_cmd = 1'b1;
        repeat (2) cyc();
        start_frame(32'h4000_0000);
        wait_frame(32, "restart");

        // Response error plus a late FRAME_START during burst 3
        err_burst = 0; err_beat = 5;
        start_frame(32'h5000_0000);
        begin
            int n = 0;
            while (ar_count < 3 && n < 1000) begin cyc(); n++; end
            check("late_wait_timeout", 64'(n < 1000), 64'(1));
        end
        FRAME_START = 1'b1;
        cyc();
        FRAME_START = 1'b0;
        check("frame_late_pulse", 64'(FRAME_LATE), 64'(1));
        check("late_no_fiforst", 64'(FIFORST), 64'(0));
        check("rd_err_held", 64'(RD_ERR), 64'(1));
        cyc();
        check("frame_late_one_cycle", 64'(FRAME_LATE), 64'(0));
        wait_frame(32, "errframe");
        check("rd_err_after_frame", 64'(RD_ERR), 64'(1));
        err_burst = -1;
        start_frame(32'h5000_1000);
        wait_frame(32, "clean");

        // Asynchronous reset in the middle of a data burst
        err_burst = 0; err_beat = 1;
        start_frame(32'h6000_0000);
        begin
            int n = 0;
            while (!(ar_count == 2 && beats_left == 4) && n < 1000) begin cyc(); n++; end
            check("mid_data_timeout", 64'(n < 1000), 64'(1));
        end
        check("pre_rst_rd_err", 64'(RD_ERR), 64'(1));
        check("pre_rst_rready", 64'(RREADY), 64'(1));
        #2 ARST = 1'b1;
        #1;
        check("arst_fiforst", 64'(FIFORST), 64'(1));
        check("arst_arvalid", 64'(ARVALID), 64'(0));
        check("arst_araddr", 64'(ARADDR), 64'(0));
        check("arst_rready", 64'(RREADY), 64'(0));
        check("arst_fifowr", 64'(FIFOWR), 64'(0));
        check("arst_fifoin", FIFOIN, 64'(0));
        check("arst_rd_err", 64'(RD_ERR), 64'(0));
        check("arst_frame_late", 64'(FRAME_LATE), 64'(0));
        err_burst = -1;
        beats_left = 0; ar_seen = 1'b0; stall_cnt = 0;
        dq.delete();
        exp_addr.delete();
        RVALID = 1'b0; RLAST = 1'b0; ARREADY = 1'b0;
        repeat (3) cyc();
        ARST = 1'b0;
        repeat (2) cyc();
        start_frame(32'h7000_0000);
        wait_frame(32, "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/disp_vram_reader.md
Name: disp_vram_reader

Overview:
- AXI4 read master that fetches one display frame from VRAM in fixed-length INCR bursts.
- Pushes the 64-bit beats into the display-side 48in/24out pixel FIFO via FIFOIN/FIFOWR, paced by that FIFO's BUF_WREADY.
- Sits in the ACLK domain, on the write end of the display FIFO.

Parameters:
H_PIXELS, 640, active pixels per line
V_LINES, 480, active lines per frame
BURST_LEN, 128, beats per AXI burst (ARLEN = BURST_LEN-1; 1..256)

Ports:
ACLK  in  1  system clock
ARST  in  1  reset, asynchronous, active-high
DISPON  in  1  display enable (level)
FRAME_START  in  1  one-ACLK pulse at start of each frame, already synchronized
VRAMSTART  in  32  frame base byte address; BURST_LEN*8-byte aligned
BUF_WREADY  in  1  FIFO has room for at least one full burst
FIFOIN  out  64  beat to FIFO; pixel0 = [23:0], pixel1 = [55:32]
FIFOWR  out  1  FIFO write strobe
FIFORST  out  1  FIFO reset
ARADDR  out  32  AXI read address
ARLEN  out  8  constant BURST_LEN-1
ARSIZE  out  3  constant 3'b011
ARBURST  out  2  constant 2'b01
ARVALID  out  1  AXI address valid
ARREADY  in  1  AXI address ready
RDATA  in  64  AXI read data
RRESP  in  2  AXI read response
RLAST  in  1  AXI last beat
RVALID  in  1  AXI data valid
RREADY  out  1  AXI data ready
RD_ERR  out  1  sticky: any RRESP != 0 seen; cleared by FRAME_START
FRAME_LATE  out  1  one-cycle pulse: FRAME_START arrived while the previous frame was still fetching

Behaviour:
- Reset values: FIFOWR=0, FIFOIN=0, FIFORST=1, ARVALID=0, ARADDR=0, RREADY=0, RD_ERR=0, FRAME_LATE=0; state IDLE.
- Constants: WORDS = H_PIXELS*V_LINES/2; NBURST = WORDS/BURST_LEN, which must be an integer. Burst stride = BURST_LEN*8 bytes; with an aligned base, no burst crosses a 4 KB boundary.
- FIFORST is registered and equals !DISPON, plus a 1-cycle pulse on any FRAME_START accepted while DISPON=1.
- States:
  - IDLE: on FRAME_START && DISPON: latch VRAMSTART into the address register, clear the burst counter and RD_ERR, go to WAIT.
  - WAIT: when BUF_WREADY && DISPON, go to ADDR. If DISPON=0, go to IDLE.
  - ADDR: ARVALID=1 with ARADDR held stable until ARREADY. On the handshake cycle, ARVALID drops next cycle and the state goes to DATA. ARVALID is never withdrawn before ARREADY, even if DISPON falls.
  - DATA: RREADY=1 for the whole state; FIFO room is guaranteed by BUF_WREADY.
    - Each RVALID beat: FIFOIN<=RDATA, FIFOWR<=1 on the next cycle (1-cycle latency). No write if the abort flag is set.
    - On RVALID && RLAST: address += stride, burst count += 1.
    - Last burst done (count == NBURST-1 before increment) → IDLE. Abort flag set → IDLE. Otherwise → WAIT.
- Abort: DISPON falling in ADDR or DATA sets the abort flag. The outstanding burst is always completed on AXI, with beats discarded and no FIFOWR. Then the block goes to IDLE and clears the flag.
- Only one burst is outstanding at a time. ARADDR is updated only in IDLE and at RLAST.
- FRAME_START outside IDLE: ignored for sequencing; FRAME_LATE pulses; no FIFORST pulse.
- RD_ERR: set on RVALID && RRESP != 0, held until the next accepted FRAME_START. The data is still written to the FIFO.
- Counters: the burst counter is clog2(NBURST+1) bits; the address counter is a 32-bit add with no wrap check (guaranteed by software).
- Asynchronous ARST at any point, including mid-burst, returns everything to reset values. AXI interconnect reset is shared, so there is no drain obligation.

Decomposition:
- Shared package disp_pkg: AXI constants (ARSIZE_8B, ARBURST_INCR, RRESP_OKAY), state typedef {IDLE, WAIT, ADDR, DATA}, and a localparam function for WORDS/NBURST.
- No sub-module; a single FSM plus datapath is natural.

Test Plan:
- Parameters H_PIXELS=16, V_LINES=4, BURST_LEN=8 (4 bursts of 8 beats) for all scenarios.
- Nominal: VRAMSTART=0x1000_0000, DISPON=1, FRAME_START, ARREADY/RVALID always 1, BUF_WREADY=1 → ARADDR sequence 0x10000000, 0x10000040, 0x10000080, 0x100000C0; 32 FIFOWR pulses, FIFOIN matches RDATA in order; then IDLE.
- Backpressure: BUF_WREADY=0 for 20 cycles after burst 1 → no ARVALID during the stall; burst 2 issues within 2 cycles of BUF_WREADY rising.
- AXI stalls: ARREADY delayed 5 cycles, RVALID toggling every other cycle → ARADDR/ARVALID stable while waiting; exactly 8 FIFOWR per burst, matching only RVALID cycles.
- Abort: DISPON drops at beat 3 of burst 2 → remaining 5 beats accepted (RREADY=1) with no FIFOWR; FIFORST=1 from the next cycle; next FRAME_START with DISPON=1 restarts at VRAMSTART.
- Errors: RRESP=2'b10 on one beat → RD_ERR=1, that beat still written; a FRAME_START during burst 3 → FRAME_LATE one-cycle pulse, fetch continues; RD_ERR clears at the next accepted FRAME_START.
- Reset: ARST asserted mid-DATA → all outputs return to reset values asynchronously, including FIFORST=1.
